// File: rtl/rec_buf_cef_pkg.sv
// Shared widths, address struct and row-address hash for the coefficient buffer bank.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

package rec_buf_cef_pkg;
  localparam int COEFF_W     = `COEFF_WIDTH;
  localparam int ROW_W       = COEFF_W * 32;
  localparam int SEL_W       = 2;
  localparam int SIZ_W       = 2;
  localparam int POS_W       = 4;
  localparam int IDX_W       = 5;
  localparam int BUF_NUM_MAX = 8;
  localparam int ADDR_W      = SEL_W + IDX_W;
  localparam int DEPTH       = 1 << ADDR_W;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SIZ_W-1:0] siz;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [IDX_W-1:0] idx;
  } cef_addr_t;

  // {sel,idx} picks the row; size and 4x4 position fold in as an XOR offset,
  // so for fixed size/position the mapping stays one-to-one.
  function automatic logic [ADDR_W-1:0] row_addr(input cef_addr_t a);
    return {a.sel, a.idx} ^ {a.siz, a.x, 1'b0} ^ {3'b000, a.y};
  endfunction
endpackage

// File: rtl/rec_buf_cef.sv
// Single coefficient row buffer: same-cycle write, RD_LAT-cycle registered read.
module rec_buf_cef
  import rec_buf_cef_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_ena,
  input  cef_addr_t        wr_addr,
  input  logic [ROW_W-1:0] wr_dat,
  input  logic             rd_ena,
  input  cef_addr_t        rd_addr,
  output logic [ROW_W-1:0] rd_dat
);
  logic [ROW_W-1:0] mem [DEPTH];
  logic [RD_LAT:1][ROW_W-1:0] dat_pipe;

  always_ff @(posedge clk)
    if (wr_ena) mem[row_addr(wr_addr)] <= wr_dat;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      dat_pipe <= '0;
    end else begin
      if (rd_ena) dat_pipe[1] <= mem[row_addr(rd_addr)];
      for (int s = 2; s <= RD_LAT; s++) dat_pipe[s] <= dat_pipe[s-1];
    end

  assign rd_dat = dat_pipe[RD_LAT];
endmodule

// File: rtl/rec_buf_cef_rot_n.sv
// Rotating bank of BUF_NUM coefficient buffers with handshaked, idle-only rotation.
// Optional REC_BUF_CEF_ROT_ERR_EN adds a sticky protocol-error flag.
module rec_buf_cef_rot_n
  import rec_buf_cef_pkg::*;
#(
  parameter int  BUF_NUM = 3,
  parameter int  RD_LAT  = 1,
  localparam int PW      = $clog2(BUF_NUM)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_i,
  input  logic                     rotate_i,
  output logic                     rotate_ack_o,
  output logic                     rotate_busy_o,
  output logic [PW-1:0]            ptr_o,
  input  logic [BUF_NUM-1:0]       wr_ena_i,
  input  logic [SEL_W*BUF_NUM-1:0] wr_sel_i,
  input  logic [SIZ_W*BUF_NUM-1:0] wr_siz_i,
  input  logic [POS_W*BUF_NUM-1:0] wr_4x4_x_i,
  input  logic [POS_W*BUF_NUM-1:0] wr_4x4_y_i,
  input  logic [IDX_W*BUF_NUM-1:0] wr_idx_i,
  input  logic [ROW_W*BUF_NUM-1:0] wr_dat_i,
  input  logic [BUF_NUM-1:0]       rd_ena_i,
  input  logic [SEL_W*BUF_NUM-1:0] rd_sel_i,
  input  logic [SIZ_W*BUF_NUM-1:0] rd_siz_i,
  input  logic [POS_W*BUF_NUM-1:0] rd_4x4_x_i,
  input  logic [POS_W*BUF_NUM-1:0] rd_4x4_y_i,
  input  logic [IDX_W*BUF_NUM-1:0] rd_idx_i,
  output logic [ROW_W*BUF_NUM-1:0] rd_dat_o,
  output logic [BUF_NUM-1:0]       rd_val_o,
  output logic                     err_o
);
  logic [PW-1:0] ptr;
  logic          pending, any_en, inflight, commit;

  cef_addr_t [BUF_NUM-1:0]            p_wr_addr, p_rd_addr;
  logic [BUF_NUM-1:0][ROW_W-1:0]      p_wr_dat, b_rd_dat;
  logic [BUF_NUM-1:0][PW-1:0]         port_buf;
  logic [RD_LAT:1][BUF_NUM-1:0]       vld_pipe;
  logic [RD_LAT:1][BUF_NUM-1:0][PW-1:0] bidx_pipe;

  assign p_wr_dat = wr_dat_i;

  assign any_en   = (|wr_ena_i) || (|rd_ena_i);
  assign inflight = |vld_pipe;
  assign commit   = pending && !any_en && !inflight;

  assign rotate_ack_o  = commit && !clr_i;
  assign rotate_busy_o = pending;
  assign ptr_o         = ptr;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ptr     <= '0;
      pending <= 1'b0;
    end else if (clr_i) begin
      ptr     <= '0;
      pending <= 1'b0;
    end else if (commit) begin
      ptr     <= (ptr == PW'(BUF_NUM-1)) ? '0 : ptr + PW'(1);
      pending <= 1'b0;
    end else if (rotate_i) begin
      pending <= 1'b1;
    end

  for (genvar p = 0; p < BUF_NUM; p++) begin : g_port
    logic [PW:0] diff;

    assign p_wr_addr[p] = '{sel: wr_sel_i[p*SEL_W +: SEL_W], siz: wr_siz_i[p*SIZ_W +: SIZ_W],
                            x: wr_4x4_x_i[p*POS_W +: POS_W], y: wr_4x4_y_i[p*POS_W +: POS_W],
                            idx: wr_idx_i[p*IDX_W +: IDX_W]};
    assign p_rd_addr[p] = '{sel: rd_sel_i[p*SEL_W +: SEL_W], siz: rd_siz_i[p*SIZ_W +: SIZ_W],
                            x: rd_4x4_x_i[p*POS_W +: POS_W], y: rd_4x4_y_i[p*POS_W +: POS_W],
                            idx: rd_idx_i[p*IDX_W +: IDX_W]};

    // buffer currently owned by this port: (p - ptr) mod BUF_NUM
    assign diff        = (PW+1)'(p + BUF_NUM) - {1'b0, ptr};
    assign port_buf[p] = (diff >= (PW+1)'(BUF_NUM)) ? PW'(diff - (PW+1)'(BUF_NUM)) : PW'(diff);

    // data follows the buffer captured at issue, not the live pointer
    assign rd_val_o[p] = vld_pipe[RD_LAT][p];
    assign rd_dat_o[p*ROW_W +: ROW_W] = vld_pipe[RD_LAT][p] ? b_rd_dat[bidx_pipe[RD_LAT][p]] : '0;
  end

  for (genvar b = 0; b < BUF_NUM; b++) begin : g_buf
    logic [PW:0]   sum;
    logic [PW-1:0] own;

    assign sum = {1'b0, ptr} + (PW+1)'(b);
    assign own = (sum >= (PW+1)'(BUF_NUM)) ? PW'(sum - (PW+1)'(BUF_NUM)) : PW'(sum);

    rec_buf_cef #(.RD_LAT(RD_LAT)) u_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_ena  (wr_ena_i[own]),
      .wr_addr (p_wr_addr[own]),
      .wr_dat  (p_wr_dat[own]),
      .rd_ena  (rd_ena_i[own]),
      .rd_addr (p_rd_addr[own]),
      .rd_dat  (b_rd_dat[b])
    );
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld_pipe  <= '0;
      bidx_pipe <= '0;
    end else begin
      vld_pipe[1]  <= rd_ena_i;
      bidx_pipe[1] <= port_buf;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        bidx_pipe[s] <= bidx_pipe[s-1];
      end
    end

`ifdef REC_BUF_CEF_ROT_ERR_EN
  logic [9:0] stall_cnt;
  logic       err;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else if (clr_i) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (pending && !commit) stall_cnt <= (stall_cnt == 10'h3FF) ? stall_cnt : stall_cnt + 10'd1;
      else                    stall_cnt <= '0;
      if ((rotate_i && pending) || (commit && any_en) || (pending && stall_cnt == 10'h3FF))
        err <= 1'b1;
    end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif
endmodule
